rd_ptr_empty_gen: RTL and testbench

- Read-domain pointer and empty-flag generator for the asynchronous FIFO.
- Sits directly downstream of the write-to-read pointer synchronizer. It consumes the 2-flop-synchronized Gray write pointer.
- It maintains the read pointer in binary and Gray form. The binary form addresses the FIFO memory; the Gray form is sent back to the read-to-write synchronizer.
- It generates registered empty, almost-empty, occupancy and underflow status for the read-side consumer.

---
 rtl/rd_ptr_empty_gen.sv | 82 ++++++++
 tb/tb_rd_ptr_empty_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rd_ptr_empty_gen.sv
// Read-side pointer and status generator for an asynchronous FIFO.
// Keeps binary/Gray read pointers and registered empty, almost-empty, occupancy and underflow flags.
module rd_ptr_empty_gen #(
  parameter int unsigned a_width   = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               rd_en,
  input  logic               clr_underflow,
  input  logic [a_width:0]   wr_syn_ptr,
  output logic [a_width-1:0] rd_addr,
  output logic [a_width:0]   rd_ptr,
  output logic               rd_accept,
  output logic               rd_empty,
  output logic               rd_almost_empty,
  output logic [a_width:0]   rd_count,
  output logic               rd_underflow
);

  logic [a_width:0] rd_bin_q, rd_bin_d;
  logic [a_width:0] rd_gray_q, rd_gray_d;
  logic [a_width:0] rd_count_q, rd_count_d;
  logic             rd_empty_q, rd_empty_d;
  logic             rd_ae_q, rd_ae_d;
  logic             rd_uf_q, rd_uf_d;
  logic [a_width:0] wr_bin;

  assign rd_accept = rd_en & ~rd_empty_q;

  // Gray-to-binary of the synchronized write pointer, XOR prefix from the MSB down.
  always_comb begin
    wr_bin          = '0;
    wr_bin[a_width] = wr_syn_ptr[a_width];
    for (int i = int'(a_width) - 1; i >= 0; i--) begin
      wr_bin[i] = wr_bin[i+1] ^ wr_syn_ptr[i];
    end
  end

  always_comb begin
    rd_bin_d   = rd_bin_q + {{a_width{1'b0}}, rd_accept};
    rd_gray_d  = (rd_bin_d >> 1) ^ rd_bin_d;
    rd_empty_d = (rd_gray_d == wr_syn_ptr);
    // Modulo subtraction keeps occupancy right across pointer wrap.
    rd_count_d = wr_bin - rd_bin_d;
    rd_ae_d    = (32'(rd_count_d) <= AE_THRESH);
    // A read attempt while empty wins over a simultaneous clear.
    if (rd_en && rd_empty_q) begin
      rd_uf_d = 1'b1;
    end else if (clr_underflow) begin
      rd_uf_d = 1'b0;
    end else begin
      rd_uf_d = rd_uf_q;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      rd_count_q <= '0;
      rd_empty_q <= 1'b1;
      rd_ae_q    <= 1'b1;
      rd_uf_q    <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      rd_count_q <= rd_count_d;
      rd_empty_q <= rd_empty_d;
      rd_ae_q    <= rd_ae_d;
      rd_uf_q    <= rd_uf_d;
    end
  end

  assign rd_addr         = rd_bin_q[a_width-1:0];
  assign rd_ptr          = rd_gray_q;
  assign rd_empty        = rd_empty_q;
  assign rd_almost_empty = rd_ae_q;
  assign rd_count        = rd_count_q;
  assign rd_underflow    = rd_uf_q;

endmodule

// File: tb/tb_rd_ptr_empty_gen.sv
// Directed bench for rd_ptr_empty_gen: vector table for fill/drain/underflow,
// hand-written sequences for wrap, full occupancy and asynchronous reset mid-read.
module tb_rd_ptr_empty_gen;

  logic       Clk;
  logic       Resetn;
  logic       rd_en;
  logic       clr_underflow;
  logic [4:0] wr_syn_ptr;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr;
  logic       rd_accept;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [4:0] rd_count;
  logic       rd_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  rd_ptr_empty_gen #(
    .a_width  (4),
    .AE_THRESH(2)
  ) dut (
    .Clk            (Clk),
    .Resetn         (Resetn),
    .rd_en          (rd_en),
    .clr_underflow  (clr_underflow),
    .wr_syn_ptr     (wr_syn_ptr),
    .rd_addr        (rd_addr),
    .rd_ptr         (rd_ptr),
    .rd_accept      (rd_accept),
    .rd_empty       (rd_empty),
    .rd_almost_empty(rd_almost_empty),
    .rd_count       (rd_count),
    .rd_underflow   (rd_underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rd_en;
    logic       clr;
    logic [4:0] wr;
    logic       acc;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       empty;
    logic       ae;
    logic [4:0] cnt;
    logic       uf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] addr, input logic [4:0] ptr,
                         input logic empty, input logic ae, input logic [4:0] cnt,
                         input logic uf);
    chk({name, ".addr"}, 32'(rd_addr), 32'(addr));
    chk({name, ".ptr"}, 32'(rd_ptr), 32'(ptr));
    chk({name, ".empty"}, 32'(rd_empty), 32'(empty));
    chk({name, ".ae"}, 32'(rd_almost_empty), 32'(ae));
    chk({name, ".cnt"}, 32'(rd_count), 32'(cnt));
    chk({name, ".uf"}, 32'(rd_underflow), 32'(uf));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Empty flag and zero occupancy must always agree out of reset.
  always @(negedge Clk) begin
    if (Resetn) chk("invariant.empty_vs_cnt", 32'(rd_empty), 32'(rd_count == 5'd0));
  end

  initial begin
    Resetn        = 1'b1;
    rd_en         = 1'b1;
    clr_underflow = 1'b0;
    wr_syn_ptr    = 5'b00010;
    #1 Resetn = 1'b0;
    #1;
    chk_all("reset.async", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset.hold", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
    end
    rd_en  = 1'b0;
    Resetn = 1'b1;

    //               en    clr   wr        acc   addr  ptr       emp   ae    cnt    uf
    vecs[0] = '{1'b0, 1'b0, 5'b00010, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 5'b00010, 1'b1, 4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 5'b00010, 1'b1, 4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'b00010, 1'b1, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 5'b00010, 1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 5'b00010, 1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 5'b00010, 1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 5'b00010, 1'b0, 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      rd_en         = vecs[v].rd_en;
      clr_underflow = vecs[v].clr;
      wr_syn_ptr    = vecs[v].wr;
      #1;
      chk($sformatf("vec%0d.acc", v), 32'(rd_accept), 32'(vecs[v].acc));
      step();
      chk_all($sformatf("vec%0d", v), vecs[v].addr, vecs[v].ptr, vecs[v].empty, vecs[v].ae,
              vecs[v].cnt, vecs[v].uf);
    end
    clr_underflow = 1'b0;

    // Wrap: write side at gray(31), read up from 3 to 31.
    rd_en      = 1'b0;
    wr_syn_ptr = 5'b10000;
    step();
    chk("wrap.preload_cnt", 32'(rd_count), 32'd28);
    for (int k = 4; k <= 31; k++) begin
      rd_en = 1'b1;
      #1;
      chk("wrap.fill_acc", 32'(rd_accept), 32'd1);
      step();
      chk("wrap.fill_addr", 32'(rd_addr), 32'(k % 16));
      chk("wrap.fill_cnt", 32'(rd_count), 32'(31 - k));
    end
    rd_en      = 1'b0;
    wr_syn_ptr = 5'b00001;
    step();
    chk_all("wrap.at31", 4'd15, 5'b10000, 1'b0, 1'b1, 5'd2, 1'b0);
    rd_en = 1'b1;
    #1;
    chk("wrap.acc", 32'(rd_accept), 32'd1);
    step();
    chk_all("wrap.to0", 4'd0, 5'b00000, 1'b0, 1'b1, 5'd1, 1'b0);

    // Full occupancy: gray(16) against rd_bin=0, then drain all sixteen.
    rd_en      = 1'b0;
    wr_syn_ptr = 5'b11000;
    step();
    chk_all("full.start", 4'd0, 5'b00000, 1'b0, 1'b0, 5'd16, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      rd_en = 1'b1;
      #1;
      chk("full.acc", 32'(rd_accept), 32'd1);
      step();
      chk("full.cnt", 32'(rd_count), 32'(16 - k));
      chk("full.empty", 32'(rd_empty), 32'(k == 16));
      chk("full.ae", 32'(rd_almost_empty), 32'((16 - k) <= 2));
    end
    rd_en = 1'b0;
    chk("full.end_ptr", 32'(rd_ptr), 32'b11000);

    // Asynchronous reset while streaming reads.
    wr_syn_ptr = 5'b11111;
    step();
    chk("mid.cnt", 32'(rd_count), 32'd5);
    rd_en = 1'b1;
    step();
    step();
    chk("mid.addr_before", 32'(rd_addr), 32'd2);
    #2 Resetn = 1'b0;
    #1;
    chk_all("mid.async", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
    chk("mid.acc", 32'(rd_accept), 32'd0);
    step();
    step();
    chk_all("mid.hold", 4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0);
    rd_en      = 1'b0;
    wr_syn_ptr = 5'b00011;
    Resetn     = 1'b1;
    step();
    chk_all("mid.release", 4'd0, 5'b00000, 1'b0, 1'b1, 5'd2, 1'b0);
    rd_en = 1'b1;
    #1;
    chk("mid.restart_acc", 32'(rd_accept), 32'd1);
    step();
    chk_all("mid.restart", 4'd1, 5'b00001, 1'b0, 1'b1, 5'd1, 1'b0);
    rd_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
